// File: rtl/draw_frame_write_arbiter.sv
// Write-port arbiter for the 160x120 draw frame: round-robin among three pixel
// requesters, plus a full-frame clear sequencer. Writes only while write_window.
module draw_frame_write_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned MEMORY_SIZE = 19200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      write_window,
    input  logic                      clear_start,
    input  logic [DATA_W-1:0]         clear_color,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic                      err_addr,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_data,
    output logic                      mem_write_a_pixel
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEMORY_SIZE - 1);

    state_t              state;
    logic [1:0]          last;
    logic                clear_pending;
    logic [DATA_W-1:0]   color_q;
    logic [ADDR_W-1:0]   count;

    logic                gnt_any;
    logic [1:0]          gnt_idx;
    logic [1:0]          cand;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_data;

    // Round-robin search starting after the last granted requester; a pending
    // clear or a closed window blocks all grants.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (state == IDLE && !clear_pending && write_window) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                cand = 2'((32'(last) + k) % NUM_REQ);
                if (!gnt_any && req[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        grant    = NUM_REQ'(gnt_any) << gnt_idx;
        gnt_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
        gnt_data = req_data[gnt_idx*DATA_W +: DATA_W];
    end

    // Control FSM with registered write port, clear counter and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            last              <= 2'd2;
            clear_pending     <= 1'b0;
            color_q           <= '0;
            count             <= '0;
            clear_done        <= 1'b0;
            err_addr          <= 1'b0;
            mem_address       <= '0;
            mem_data          <= '0;
            mem_write_a_pixel <= 1'b0;
        end else begin
            mem_write_a_pixel <= 1'b0;
            clear_done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_pending && write_window) begin
                        // clear_start on this edge is dropped: it would re-arm a fill
                        clear_pending <= 1'b0;
                        count         <= '0;
                        state         <= CLEAR;
                    end else begin
                        if (clear_start) begin
                            clear_pending <= 1'b1;
                            color_q       <= clear_color;
                        end
                        if (gnt_any) begin
                            last        <= gnt_idx;
                            mem_address <= gnt_addr;
                            mem_data    <= gnt_data;
                            if (32'(gnt_addr) < MEMORY_SIZE)
                                mem_write_a_pixel <= 1'b1;
                            else
                                err_addr <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (write_window) begin
                        mem_address       <= count;
                        mem_data          <= color_q;
                        mem_write_a_pixel <= 1'b1;
                        if (count == LAST_ADDR) begin
                            state      <= DONE;
                            clear_done <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign clear_busy = clear_pending | (state == CLEAR);

endmodule

// File: doc/draw_frame_write_arbiter.md
# draw_frame_write_arbiter

Shares the single write port of the 160x120 draw frame (address/data/write-a-pixel inputs of the VGA frame driver) among three pixel requesters. It also contains a built-in clear sequencer that fills the whole frame with one colour. Writes are issued only while `write_window` is high, so the driver's per-pixel read of the draw frame is never pre-empted during active display. It sits between the drawing engines and the frame driver, on the same `clk` domain.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters. Fixed at 3 in this revision.
- `ADDR_W`, 15: draw-frame address width.
- `DATA_W`, 24: pixel width, {R,G,B} 8 bits each.
- `MEMORY_SIZE`, 19200: number of valid addresses, 160*120.

Ports:
- `clk`  in  1: system clock. One clock; the block has no other clock.
- `rst`  in  1: reset, synchronous, active-high.
- `req`  in  3: per-requester write request. Held high with address and data stable until granted.
- `req_addr`  in  45: packed addresses. Requester i uses bits [15i+14:15i].
- `req_data`  in  72: packed pixels. Requester i uses bits [24i+23:24i].
- `grant`  out  3: one-hot, combinational. The write is accepted on the rising edge where `req[i]&grant[i]`.
- `write_window`  in  1: high when draw-frame writes are permitted. Driven externally, typically `!active_pixels`.
- `clear_start`  in  1: one-cycle pulse requesting a full-frame fill.
- `clear_color`  in  24: fill value. Sampled on the cycle `clear_start` is accepted.
- `clear_busy`  out  1: high while a clear is pending or running.
- `clear_done`  out  1: one-cycle pulse after the last clear write is issued.
- `err_addr`  out  1: sticky flag. Set when a granted address is >= `MEMORY_SIZE`.
- `mem_address`  out  15: to the draw-frame write address input.
- `mem_data`  out  24: to the draw-frame write data input.
- `mem_write_a_pixel`  out  1: write strobe, registered.

## Operation
- States:
  - IDLE: arbitration.
  - CLEAR: fill in progress.
  - DONE: one cycle.
- Clear request latching:
  - `clear_start` in IDLE sets `clear_pending` and latches `clear_color`.
  - `clear_start` in CLEAR or DONE is ignored.
- IDLE → CLEAR when `clear_pending && write_window`. On this transition `clear_pending` is cleared and the counter is loaded with 0.
- Grant condition in IDLE:
  - `grant` is nonzero only when the state is IDLE, `!clear_pending`, `write_window` is high and `|req`.
  - A pending clear therefore has priority over all requesters.
- Round-robin arbitration:
  - Pointer `last` (2 bits) holds the last granted index.
  - Search order is `last+1`, `last+2`, `last+3`, mod 3. The first requester found with `req` high is granted.
  - `last` is updated only on an accepted grant.
  - Reset value of `last` is 2, so req0 wins first.
- On an accepted grant, the next cycle has:
  - `mem_address` = the granted address.
  - `mem_data` = the granted data.
  - `mem_write_a_pixel` = 1 if the address is < 19200.
  - If the address is >= 19200, the strobe is 0 and `err_addr` is set. The request is still consumed.
- Throughput is one accepted write per cycle.
- CLEAR state:
  - Each cycle with `write_window` high: issue a write of (counter, `clear_color`), then increment the counter.
  - Each cycle with `write_window` low: counter holds and the strobe is 0.
  - After issuing address 19199 the state goes to DONE.
- DONE: pulse `clear_done`, then return to IDLE.
- `clear_busy` = `clear_pending` OR (state == CLEAR). It is low in DONE.
- `err_addr` is cleared only by `rst`.

## Timing
- Reset values:
  - All outputs are 0: `grant`, `mem_*`, `clear_busy`, `clear_done`, `err_addr`.
  - State = IDLE, `last` = 2, `clear_pending` = 0, counter = 0.
- Reset mid-clear or mid-grant: the block aborts on the next edge. No further strobes are issued after the reset edge.
- Grant latency: 0 cycles, combinational. Write-strobe latency: 1 cycle after acceptance.
- Strobe width: `mem_write_a_pixel` is a single-cycle pulse per write. `mem_address` and `mem_data` hold their last values when no write is issued.
- Window falling edge: with `write_window` low in cycle N, no grant occurs in N and no strobe occurs in N+1. A write accepted in N-1 still strobes in N.
- Clear duration: 19200 window-high cycles, plus 1 cycle for IDLE→CLEAR, plus 1 DONE cycle.
- Simultaneous `clear_start` and `req` in IDLE with window high: the request is granted this cycle, because `clear_pending` is not yet set. The clear starts on the next window-high cycle.
- Simultaneous `clear_start` on the IDLE→CLEAR transition edge: ignored.
- Counter width: 15 bits. Terminal compare is at 19199; there is no wrap past it.

## Test plan
- Reset then all three `req` held high with window high → grants in order 001, 010, 100, 001 on consecutive cycles. Strobes follow one cycle later with the matching addresses.
- req1 only, addr 0x4B00 (=19200), window high → `grant`=010. Next cycle the strobe is 0 and `err_addr` goes to 1 and stays 1 until `rst`.
- `clear_start` with `clear_color`=0x00FF00 and window always high → `clear_busy` is high. 19200 strobes are issued with addresses 0..19199, all data 0x00FF00. `clear_done` pulses exactly once, one cycle after address 19199.
- Clear with window toggling every 100 cycles → no address is skipped or repeated. No strobe occurs in any cycle following a window-low cycle.
- `rst` asserted at clear address 5000 → no strobe after the reset edge, `clear_busy`=0. After release, `req0` is granted first.
- `req` held high while `clear_pending` is set → `grant`=000 for the whole clear. The request is granted in the cycle after DONE.
